// File: rtl/leitor_vizinhos.sv
// -----------------------------------------------------------------------------
// leitor_vizinhos
//
// Neighbour-list reader. It owns one solicitation slot on the read arbiter
// (gerenciador_leituras). A job is a base word address plus a neighbour count.
// The reader walks the list in wide beats of NUM_READ_PORTS consecutive words.
// For each beat it raises a request and waits for the one-cycle grant. It then
// captures the returned words MEM_LATENCY edges later and presents them to the
// expander through a one-entry valid/ready buffer.
//
// The address arithmetic wraps modulo 2**ADDR_WIDTH. On the last beat,
// lanes past the end of the list are marked invalid in lane_valid_out.
//
// Ports
//   clk                in   clock
//   rst                in   synchronous reset, active-high; aborts any job
//   start_in           in   job start pulse, only honoured while idle
//   base_addr_in       in   first neighbour word address
//   num_vizinhos_in    in   number of neighbour words in the job
//   busy_out           out  job in progress (request, wait or output phase)
//   done_out           out  one-cycle pulse when the job has finished
//   lvv_read_en_out    out  read request to the arbiter
//   lvv_read_addr_out  out  lane p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   ready_in           in   arbiter grant pulse for this slot
//   read_data_in       in   memory data returned through the arbiter
//   data_out           out  captured beat, lane p at [p*DATA_WIDH +: DATA_WIDH]
//   lane_valid_out     out  per-lane valid mask for data_out
//   data_valid_out     out  beat available to the consumer
//   data_ready_in      in   consumer accepts the beat on this edge
// -----------------------------------------------------------------------------
module leitor_vizinhos #(
    parameter int NUM_READ_PORTS = 8,
    parameter int DATA_WIDH      = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_in,
    input  logic [ADDR_WIDTH-1:0]                base_addr_in,
    input  logic [CNT_WIDTH-1:0]                 num_vizinhos_in,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 lvv_read_en_out,
    output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] lvv_read_addr_out,
    input  logic                                 ready_in,
    input  logic [DATA_WIDH*NUM_READ_PORTS-1:0]  read_data_in,
    output logic [DATA_WIDH*NUM_READ_PORTS-1:0]  data_out,
    output logic [NUM_READ_PORTS-1:0]            lane_valid_out,
    output logic                                 data_valid_out,
    input  logic                                 data_ready_in
);

    // Lane index width, and a word-position width large enough that
    // beat*NUM_READ_PORTS + lane can never overflow before it is compared
    // with the count.
    localparam int LANE_W = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
    localparam int POS_W  = CNT_WIDTH + LANE_W + 1;
    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        OUT,
        FIN
    } state_t;

    state_t state, state_next;

    // Job context and per-beat datapath registers.
    logic [ADDR_WIDTH-1:0]                base_q;
    logic [CNT_WIDTH-1:0]                 count_q;
    logic [CNT_WIDTH-1:0]                 beat_q;
    logic [LAT_W-1:0]                     lat_q;
    logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] addr_q;
    logic [DATA_WIDH*NUM_READ_PORTS-1:0]  data_q;
    logic [NUM_READ_PORTS-1:0]            lane_q;

    // Decoded events used by both the FSM and the datapath.
    logic job_start;
    logic grant;
    logic capture;
    logic accept;
    logic last_beat;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Address of every lane for a given beat. The sum is truncated to
    // ADDR_WIDTH on purpose, so a list that runs past the top of the address
    // space wraps to address 0.
    function automatic logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] lane_addrs(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [CNT_WIDTH-1:0]  beat
    );
        logic [POS_W-1:0] pos;
        lane_addrs = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            pos = POS_W'(beat) * POS_W'(NUM_READ_PORTS) + POS_W'(p);
            lane_addrs[p*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'(pos);
        end
    endfunction

    // A lane is valid when its word position lies inside the list.
    function automatic logic [NUM_READ_PORTS-1:0] lane_mask(
        input logic [CNT_WIDTH-1:0] count,
        input logic [CNT_WIDTH-1:0] beat
    );
        logic [POS_W-1:0] pos;
        lane_mask = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            pos = POS_W'(beat) * POS_W'(NUM_READ_PORTS) + POS_W'(p);
            lane_mask[p] = (pos < POS_W'(count));
        end
    endfunction

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign job_start = (state == IDLE) && start_in;
    assign grant     = (state == REQ) && ready_in;
    assign capture   = (state == WAIT_DATA) && (lat_q == LAT_W'(MEM_LATENCY));
    assign accept    = (state == OUT) && data_ready_in;

    // This is the last beat once the words covered so far reach the count.
    assign last_beat = ((POS_W'(beat_q) + POS_W'(1)) * POS_W'(NUM_READ_PORTS))
                       >= POS_W'(count_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of
    // process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = (num_vizinhos_in == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                // The request is held until the grant pulse is sampled.
                if (ready_in) begin
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (capture) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                // While the consumer holds the beat, no new request is made.
                if (data_ready_in) begin
                    state_next = last_beat ? FIN : REQ;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        lvv_read_en_out = 1'b0;
        busy_out        = 1'b0;
        data_valid_out  = 1'b0;
        done_out        = 1'b0;
        unique case (state)
            REQ: begin
                lvv_read_en_out = 1'b1;
                busy_out        = 1'b1;
            end
            WAIT_DATA: begin
                busy_out = 1'b1;
            end
            OUT: begin
                busy_out       = 1'b1;
                data_valid_out = 1'b1;
            end
            FIN: begin
                done_out = 1'b1;
            end
            default: begin
                lvv_read_en_out = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: the data and mask registers are reset as well, because the
    // interface promises all-zero outputs after reset, not just an idle FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lane_q  <= '0;
        end else begin
            if (job_start) begin
                base_q  <= base_addr_in;
                count_q <= num_vizinhos_in;
                beat_q  <= '0;
                addr_q  <= lane_addrs(base_addr_in, '0);
            end

            // The grant edge is the first of the MEM_LATENCY edges, so the
            // counter starts at 1. Capture happens when it reaches
            // MEM_LATENCY.
            if (grant) begin
                lat_q <= LAT_W'(1);
            end else if ((state == WAIT_DATA) && !capture) begin
                lat_q <= lat_q + LAT_W'(1);
            end

            if (capture) begin
                data_q <= read_data_in;
                lane_q <= lane_mask(count_q, beat_q);
            end

            // The next beat's addresses are set up while leaving OUT, so they
            // are already stable when the request re-asserts.
            if (accept && !last_beat) begin
                beat_q <= beat_q + CNT_WIDTH'(1);
                addr_q <= lane_addrs(base_q, beat_q + CNT_WIDTH'(1));
            end
        end
    end

    assign lvv_read_addr_out = addr_q;
    assign data_out          = data_q;
    assign lane_valid_out    = lane_q;

endmodule

// File: tb/tb_leitor_vizinhos.sv
// -----------------------------------------------------------------------------
// tb_leitor_vizinhos
//
// Directed bench for leitor_vizinhos. The bench plays the arbiter and the
// memory. Memory contents are a fixed function of the word address. When a
// grant is given, the expected beat is built from the bench's own address
// model and pushed to a queue. It is popped and compared when the reader
// presents the beat. Outside the single capture cycle, read_data_in carries
// filler, so a capture on the wrong edge shows up as wrong data.
// -----------------------------------------------------------------------------
module tb_leitor_vizinhos;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 8;
    localparam int WW = DW * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_in;
    logic [AW-1:0]   base_addr_in;
    logic [CW-1:0]   num_vizinhos_in;
    logic            busy_out;
    logic            done_out;
    logic            lvv_read_en_out;
    logic [AW*N-1:0] lvv_read_addr_out;
    logic            ready_in;
    logic [WW-1:0]   read_data_in;
    logic [WW-1:0]   data_out;
    logic [N-1:0]    lane_valid_out;
    logic            data_valid_out;
    logic            data_ready_in;

    typedef struct {
        logic [WW-1:0] data;
        logic [N-1:0]  lanes;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    leitor_vizinhos #(
        .NUM_READ_PORTS(N),
        .DATA_WIDH     (DW),
        .ADDR_WIDTH    (AW),
        .CNT_WIDTH     (CW),
        .MEM_LATENCY   (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .base_addr_in     (base_addr_in),
        .num_vizinhos_in  (num_vizinhos_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .lvv_read_en_out  (lvv_read_en_out),
        .lvv_read_addr_out(lvv_read_addr_out),
        .ready_in         (ready_in),
        .read_data_in     (read_data_in),
        .data_out         (data_out),
        .lane_valid_out   (lane_valid_out),
        .data_valid_out   (data_valid_out),
        .data_ready_in    (data_ready_in)
    );

    task automatic check(input string tag, input logic [WW-1:0] observed,
                         input logic [WW-1:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 8'hD0, a, ~a, a ^ 8'h5A};
    endfunction

    function automatic logic [AW*N-1:0] model_addrs(input logic [AW-1:0] base, input int beat);
        logic [AW*N-1:0] r;
        r = '0;
        for (int p = 0; p < N; p++) r[p*AW +: AW] = base + AW'(beat * N + p);
        return r;
    endfunction

    function automatic logic [N-1:0] model_lanes(input int count, input int beat);
        logic [N-1:0] r;
        r = '0;
        for (int p = 0; p < N; p++) r[p] = (beat * N + p) < count;
        return r;
    endfunction

    function automatic logic [WW-1:0] model_data(input logic [AW*N-1:0] addrs);
        logic [WW-1:0] r;
        for (int p = 0; p < N; p++) r[p*DW +: DW] = mem_word(addrs[p*AW +: AW]);
        return r;
    endfunction

    function automatic logic [WW-1:0] filler();
        logic [WW-1:0] r;
        for (int p = 0; p < N; p++) r[p*DW +: DW] = 32'hDEADBEEF;
        return r;
    endfunction

    task automatic start_job(input logic [AW-1:0] base, input int count);
        start_in        = 1'b1;
        base_addr_in    = base;
        num_vizinhos_in = CW'(count);
        @(negedge clk);
        start_in        = 1'b0;
    endtask

    // Entered at a negedge with the reader in REQ. The reader is granted
    // after grant_delay request cycles, and the beat is held for hold cycles
    // before it is accepted.
    task automatic serve_beat(input logic [AW-1:0] base, input int count, input int beat,
                              input int grant_delay, input int hold);
        beat_t         exp_beat;
        beat_t         got;
        logic [WW-1:0] held;
        for (int i = 0; i < grant_delay; i++) begin
            check("req_en", lvv_read_en_out, 1'b1);
            check("req_busy", busy_out, 1'b1);
            check("req_addr", lvv_read_addr_out, model_addrs(base, beat));
            if (i < grant_delay - 1) @(negedge clk);
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        // The memory answers for whatever address the reader is driving.
        read_data_in   = model_data(lvv_read_addr_out);
        exp_beat.data  = model_data(model_addrs(base, beat));
        exp_beat.lanes = model_lanes(count, beat);
        sb.push_back(exp_beat);
        @(negedge clk);
        check("wait_en", lvv_read_en_out, 1'b0);
        check("wait_valid", data_valid_out, 1'b0);
        check("wait_addr", lvv_read_addr_out, model_addrs(base, beat));
        @(posedge clk);
        #1;
        read_data_in = filler();
        @(negedge clk);
        check("out_valid", data_valid_out, 1'b1);
        check("out_en", lvv_read_en_out, 1'b0);
        check("sb_pending", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("out_data", data_out, got.data);
            check("out_lanes", lane_valid_out, got.lanes);
        end
        held = data_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", data_valid_out, 1'b1);
            check("hold_data", data_out, held);
            check("hold_en", lvv_read_en_out, 1'b0);
        end
        data_ready_in = 1'b1;
        @(negedge clk);
        data_ready_in = 1'b0;
    endtask

    // Entered at the negedge following the last accept.
    task automatic finish_job();
        check("fin_done", done_out, 1'b1);
        check("fin_busy", busy_out, 1'b0);
        check("fin_en", lvv_read_en_out, 1'b0);
        check("fin_valid", data_valid_out, 1'b0);
        @(negedge clk);
        check("idle_done", done_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        start_in        = 1'b0;
        base_addr_in    = '0;
        num_vizinhos_in = '0;
        ready_in        = 1'b0;
        read_data_in    = filler();
        data_ready_in   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_en", lvv_read_en_out, 1'b0);
        check("rst_addr", lvv_read_addr_out, '0);
        check("rst_data", data_out, '0);
        check("rst_lanes", lane_valid_out, '0);
        check("rst_valid", data_valid_out, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single full beat, grant after three request cycles.
        start_job(8'h10, 8);
        serve_beat(8'h10, 8, 0, 3, 0);
        finish_job();

        // Two beats, the second one partial (three valid lanes).
        start_job(8'h00, 11);
        serve_beat(8'h00, 11, 0, 1, 0);
        serve_beat(8'h00, 11, 1, 2, 0);
        finish_job();

        // Addresses wrap past 0xFF.
        start_job(8'hFC, 8);
        serve_beat(8'hFC, 8, 0, 1, 0);
        finish_job();

        // Empty job: done on the next cycle, no request.
        start_job(8'h33, 0);
        check("zero_done", done_out, 1'b1);
        check("zero_en", lvv_read_en_out, 1'b0);
        check("zero_busy", busy_out, 1'b0);
        @(negedge clk);
        check("zero_done_end", done_out, 1'b0);
        check("zero_en_end", lvv_read_en_out, 1'b0);

        // A second start while busy is ignored. The first beat is held
        // under backpressure, then accepted, and the request re-asserts.
        start_job(8'h50, 16);
        start_in        = 1'b1;
        base_addr_in    = 8'h90;
        num_vizinhos_in = 8'd3;
        @(negedge clk);
        start_in        = 1'b0;
        serve_beat(8'h50, 16, 0, 1, 5);
        serve_beat(8'h50, 16, 1, 1, 0);
        finish_job();

        // Reset in WAIT_DATA aborts the job. A late grant is ignored.
        start_job(8'h20, 8);
        check("abort_en", lvv_read_en_out, 1'b1);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in     = 1'b0;
        read_data_in = model_data(lvv_read_addr_out);
        @(negedge clk);
        check("abort_wait_busy", busy_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        read_data_in = filler();
        check("abort_busy", busy_out, 1'b0);
        check("abort_en0", lvv_read_en_out, 1'b0);
        check("abort_addr", lvv_read_addr_out, '0);
        check("abort_data", data_out, '0);
        check("abort_lanes", lane_valid_out, '0);
        check("abort_valid", data_valid_out, 1'b0);
        check("abort_done", done_out, 1'b0);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        @(negedge clk);
        check("late_grant_en", lvv_read_en_out, 1'b0);
        check("late_grant_busy", busy_out, 1'b0);
        check("late_grant_valid", data_valid_out, 1'b0);

        // Recovery after the abort: a short partial job.
        start_job(8'h00, 3);
        serve_beat(8'h00, 3, 0, 1, 0);
        finish_job();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
